// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, types and default coefficients for the FIR datapath
package fir_pkg;
  localparam int DIN_W = 18;
  localparam int COEF_W = 18;
  localparam int PROD_W = 36;
  localparam int DOUT_W = 54;
  localparam int NTAPS_DEFAULT = 8;
  typedef logic signed [DIN_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [DOUT_W-1:0] acc_t;
  localparam coef_t COEFFS_DEFAULT [NTAPS_DEFAULT] = '{
    18'sd1, 18'sd2, 18'sd3, 18'sd4, 18'sd4, 18'sd3, 18'sd2, 18'sd1
  };
endpackage

// File: rtl/fir_tap.sv
// fir_tap: one delay-line stage followed by a registered constant multiply
module fir_tap
  import fir_pkg::*;
#(
  parameter int DIN_W = fir_pkg::DIN_W,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int PROD_W = fir_pkg::PROD_W,
  parameter logic signed [COEF_W-1:0] COEF = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic signed [DIN_W-1:0]  x_i,
  output logic signed [DIN_W-1:0]  x_o,
  output logic signed [PROD_W-1:0] p_o
);
  logic signed [DIN_W-1:0] x_q, x_d;
  logic signed [PROD_W-1:0] p_q, p_d;
  // Both operands widened to the full product width so the multiply is exact and signed
  always_comb begin
    x_d = x_i;
    p_d = PROD_W'(x_q) * PROD_W'(COEF);
  end
  // Delay register feeds the product register; the whole tap stalls when ena is low
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      p_q <= '0;
    end else if (ena) begin
      x_q <= x_d;
      p_q <= p_d;
    end
  end
  assign x_o = x_q;
  assign p_o = p_q;
endmodule

// File: rtl/fir_filter_top.sv
// fir_filter_top: pipelined direct-form FIR (delay, multiply, sum-and-register)
module fir_filter_top
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEFAULT,
  parameter int DIN_W = fir_pkg::DIN_W,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int DOUT_W = fir_pkg::DOUT_W,
  parameter coef_t COEFFS [NTAPS] = COEFFS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic signed [DIN_W-1:0]  x_in,
  output logic signed [DOUT_W-1:0] dout
);
  localparam int PROD_W = DIN_W + COEF_W;
  logic signed [DIN_W-1:0] xs [NTAPS+1];
  logic signed [PROD_W-1:0] p [NTAPS];
  logic signed [DOUT_W-1:0] dout_q, dout_d;
  logic unused_tail;
  assign xs[0] = x_in;
  assign unused_tail = ^xs[NTAPS];
  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    fir_tap #(
      .DIN_W(DIN_W),
      .COEF_W(COEF_W),
      .PROD_W(PROD_W),
      .COEF(COEFFS[k])
    ) u_tap (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .x_i(xs[k]),
      .x_o(xs[k+1]),
      .p_o(p[k])
    );
  end
  // Linear adder chain; products are sign-extended to the accumulator width first
  always_comb begin
    dout_d = '0;
    for (int k = 0; k < NTAPS; k++)
      dout_d = dout_d + {{(DOUT_W-PROD_W){p[k][PROD_W-1]}}, p[k]};
  end
  // Output register, held while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else if (ena) dout_q <= dout_d;
  end
  assign dout = dout_q;
endmodule

// File: tb/tb_fir_filter_top.sv
// tb_fir_filter_top: directed checks of reset, impulse, step, stall and mid-stream reset
module tb_fir_filter_top;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b0;
  logic signed [17:0] x_in = '0;
  logic signed [53:0] dout;
  int n_tests = 0;
  int n_fail = 0;
  int h [8] = '{1, 2, 3, 4, 4, 3, 2, 1};

  fir_filter_top dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .x_in(x_in),
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint expv);
    logic signed [53:0] e;
    e = 54'(expv);
    n_tests++;
    assert (dout === e) else begin
      n_fail++;
      $error("FAIL %s: dout=%0d expected=%0d", tag, dout, e);
    end
  endtask

  initial begin
    #1;
    rst = 1'b1; ena = 1'b0; x_in = '0;
    tick();
    chk("reset", 0);
    rst = 1'b0; ena = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_zero", 0);
    end
    x_in = 18'sd1000;
    tick();
    x_in = '0;
    chk("imp_lat0", 0);
    tick();
    chk("imp_lat1", 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("impulse", 1000 * h[i]);
      tick();
    end
    chk("imp_tail", 0);
    x_in = -18'sd1;
    tick();
    x_in = '0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("neg_impulse", -h[i]);
      tick();
    end
    chk("neg_tail", 0);
    x_in = 18'sd131071;
    for (int i = 0; i < 10; i++) tick();
    chk("step_max", 2621420);
    tick();
    chk("step_max_hold", 2621420);
    x_in = -18'sd131072;
    for (int i = 0; i < 10; i++) tick();
    chk("step_min", -2621440);
    x_in = '0;
    for (int i = 0; i < 10; i++) tick();
    chk("flush", 0);
    x_in = 18'sd1000;
    tick();
    x_in = '0;
    tick();
    tick();
    chk("stall_pre1", 1000);
    tick();
    chk("stall_pre2", 2000);
    ena = 1'b0;
    x_in = 18'sd77;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", 2000);
    end
    ena = 1'b1;
    x_in = '0;
    for (int i = 2; i < 8; i++) begin
      tick();
      chk("stall_resume", 1000 * h[i]);
    end
    tick();
    chk("stall_tail", 0);
    x_in = 18'sd1000;
    tick();
    x_in = '0;
    tick();
    tick();
    tick();
    tick();
    chk("rst_pre", 3000);
    rst = 1'b1;
    tick();
    chk("rst_mid", 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_after", 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
